// File: rtl/mig_rw_ctrl.sv
// DDR3 bring-up traffic generator/checker on the MIG app_* UI: writes BURST_LEN pattern beats, reads them back, compares.
// Outputs decode from registered state (no extra latency); commands and write data each hold until their own rdy accepts them.
module mig_rw_ctrl #(
  parameter int          ADDR_W     = 28,
  parameter int          DATA_W     = 128,
  parameter int          BURST_LEN  = 64,
  parameter int          ADDR_STEP  = 8,
  parameter int unsigned START_ADDR = 0,
  parameter logic [31:0] PAT_SEED   = 32'hA5A5_0000,
  parameter int          TIMEOUT    = 4096
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  init_calib_complete,
  input  logic                  start,
  output logic [ADDR_W-1:0]     app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [DATA_W-1:0]     app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [DATA_W/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_rdy,
  input  logic [DATA_W-1:0]     app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  timeout,
  output logic [15:0]           err_cnt
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BL      = CW'(BURST_LEN);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     wc_q, wc_d, wd_q, wd_d, rc_q, rc_d, rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     wdog_q, wdog_d;
  logic              err_q, err_d, to_q, to_d;
  logic [15:0]       cnt_q, cnt_d;

  logic wr_cmd_vld, wr_dat_vld, rd_cmd_vld, cmd_acc, dat_acc, beat;

  function automatic logic [DATA_W-1:0] pat(input logic [CW-1:0] i);
    return {(DATA_W/32){PAT_SEED + 32'(i)}};
  endfunction

  assign wr_cmd_vld = (state_q == S_WRITE) && (wc_q < BL);
  assign wr_dat_vld = (state_q == S_WRITE) && (wd_q < BL);
  assign rd_cmd_vld = (state_q == S_READ)  && (rc_q < BL);
  assign cmd_acc    = (wr_cmd_vld || rd_cmd_vld) && app_rdy;
  assign dat_acc    = wr_dat_vld && app_wdf_rdy;
  assign beat       = (state_q == S_READ) && app_rd_data_valid && (rd_q < BL);

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    wd_d    = wd_q;
    rc_d    = rc_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    to_d    = to_q;
    cnt_d   = cnt_q;

    // Handshakes are counted even in the cycle an abort is taken.
    if (cmd_acc) begin
      addr_d = addr_q + ADDR_W'(ADDR_STEP);
      if (state_q == S_WRITE) wc_d = wc_q + CW'(1);
      else                    rc_d = rc_q + CW'(1);
    end
    if (dat_acc) wd_d = wd_q + CW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start && init_calib_complete) begin
          state_d = S_WRITE;
          err_d   = 1'b0;
          to_d    = 1'b0;
          cnt_d   = '0;
          wc_d    = '0;
          wd_d    = '0;
          rc_d    = '0;
          rd_d    = '0;
          addr_d  = ADDR_W'(START_ADDR);
        end
      end
      S_WRITE: begin
        if (!init_calib_complete) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (wc_q == BL && wd_q == BL) begin
          state_d = S_READ;
          addr_d  = ADDR_W'(START_ADDR);
          wdog_d  = '0;
        end
      end
      S_READ: begin
        if (beat) begin
          rd_d   = rd_q + CW'(1);
          wdog_d = '0;
          if (app_rd_data != pat(rd_q)) begin
            err_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
        if (!init_calib_complete) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (rd_q == BL) begin
          state_d = S_FIN;
        end else if (!beat && wdog_q == TO_LAST) begin
          to_d    = 1'b1;
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wc_q    <= '0;
      wd_q    <= '0;
      rc_q    <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      wd_q    <= wd_d;
      rc_q    <= rc_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign app_en       = wr_cmd_vld || rd_cmd_vld;
  assign app_cmd      = (state_q == S_READ) ? 3'b001 : 3'b000;
  assign app_addr     = addr_q;
  assign app_wdf_wren = wr_dat_vld;
  assign app_wdf_end  = wr_dat_vld;
  assign app_wdf_data = wr_dat_vld ? pat(wd_q) : '0;
  assign app_wdf_mask = '0;
  assign busy         = (state_q == S_WRITE) || (state_q == S_READ);
  assign done         = (state_q == S_FIN);
  assign err          = err_q;
  assign timeout      = to_q;
  assign err_cnt      = cnt_q;

endmodule
